// File: rtl/hot_page_queue.sv
// hot_page_queue: circular buffer of hot-page reports {addr, cnt} with a FWFT read port,
// overflow drop counting and epoch flush. Defining HOTQ_DEDUP_EN adds a recent-address filter.
module hot_page_queue #(
   parameter int ADDR_SIZE     = 21,
   parameter int CNT_SIZE      = 12,
   parameter int DEPTH         = 64,
   parameter int WM_LEVEL      = 48,
   parameter int DROP_CNT_SIZE = 16,
   parameter int DEDUP_DEPTH   = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     epoch,
   input  logic [ADDR_SIZE-1:0]     in_addr,
   input  logic [CNT_SIZE-1:0]      in_cnt,
   input  logic                     in_valid,
   output logic [ADDR_SIZE-1:0]     out_addr,
   output logic [CNT_SIZE-1:0]      out_cnt,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     watermark_irq,
   output logic [DROP_CNT_SIZE-1:0] drop_cnt,
   output logic                     overflow,
   input  logic                     drop_clr
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int ENT_W = ADDR_SIZE + CNT_SIZE;
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
   localparam logic [LVL_W-1:0] WM_LVL   = LVL_W'(WM_LEVEL);

   if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || WM_LEVEL < 1 || WM_LEVEL > DEPTH ||
       DEDUP_DEPTH < 1) begin : g_bad_param
      $error("hot_page_queue: illegal parameter set");
   end

   logic [ENT_W-1:0]         mem_q [DEPTH];
   logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]         level_q, level_d;
   logic                     wm_q, wm_d;
   logic [DROP_CNT_SIZE-1:0] drop_cnt_q, drop_cnt_d;
   logic                     ovf_q, ovf_d;
   logic                     full, dup, accept, push, drop, pop;
   logic [ENT_W-1:0]         head;

`ifdef HOTQ_DEDUP_EN
   localparam int DD_W = (DEDUP_DEPTH > 1) ? $clog2(DEDUP_DEPTH) : 1;
   localparam logic [DD_W-1:0] DD_LAST = DD_W'(DEDUP_DEPTH - 1);

   logic [ADDR_SIZE-1:0]   dd_addr_q [DEDUP_DEPTH];
   logic [DEDUP_DEPTH-1:0] dd_vld_q;
   logic [DD_W-1:0]        dd_ptr_q;

   always_comb begin
      dup = 1'b0;
      for (int i = 0; i < DEDUP_DEPTH; i++) begin
         if (dd_vld_q[i] && (dd_addr_q[i] == in_addr)) dup = 1'b1;
      end
   end

   // Only accepted pushes enter the table; the address slots need no reset.
   always_ff @(posedge clk) begin
      if (!rst_n || epoch) begin
         dd_vld_q <= '0;
         dd_ptr_q <= '0;
      end else if (push) begin
         dd_addr_q[dd_ptr_q] <= in_addr;
         dd_vld_q[dd_ptr_q]  <= 1'b1;
         dd_ptr_q            <= (dd_ptr_q == DD_LAST) ? '0 : dd_ptr_q + 1'b1;
      end
   end
`else
   assign dup = 1'b0;
`endif

   // Read port: out_valid means the head entry is presented; it is consumed on a clk edge
   // where out_valid && out_ready. Upstream has no ready, so a report hitting a full queue is dropped.
   assign full      = (level_q == FULL_LVL);
   assign accept    = in_valid && !dup && !epoch;
   assign push      = accept && !full;
   assign drop      = accept && full;
   assign out_valid = (level_q != '0);
   assign pop       = out_valid && out_ready && !epoch;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      drop_cnt_d = drop_cnt_q;
      ovf_d      = ovf_q;
      if (epoch) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (push && !pop)      level_d = level_q + 1'b1;
         else if (pop && !push) level_d = level_q - 1'b1;
      end
      wm_d = (level_d >= WM_LVL);
      if (drop_clr) begin
         drop_cnt_d = {{(DROP_CNT_SIZE-1){1'b0}}, drop};
         ovf_d      = drop;
      end else if (drop) begin
         if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         wm_q       <= 1'b0;
         drop_cnt_q <= '0;
         ovf_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         wm_q       <= wm_d;
         drop_cnt_q <= drop_cnt_d;
         ovf_q      <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {in_addr, in_cnt};
   end

   assign head          = mem_q[rd_ptr_q];
   assign out_addr      = out_valid ? head[ENT_W-1:CNT_SIZE] : '0;
   assign out_cnt       = out_valid ? head[CNT_SIZE-1:0] : '0;
   assign level         = level_q;
   assign watermark_irq = wm_q;
   assign drop_cnt      = drop_cnt_q;
   assign overflow      = ovf_q;

endmodule

// File: tb/tb_hot_page_queue.sv
// tb_hot_page_queue: directed and randomized stimulus for hot_page_queue; a queue-based model
// predicts accepted reports and status, a separate monitor pops and compares every cycle.
module tb_hot_page_queue;
   localparam int A     = 21;
   localparam int C     = 12;
   localparam int DEPTH = 64;
   localparam int WM    = 48;
   localparam int DW    = 6;
   localparam int DD    = 8;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         epoch = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic         drop_clr = 1'b0;
   logic [A-1:0] in_addr = '0;
   logic [C-1:0] in_cnt = '0;

   logic [A-1:0]  out_addr;
   logic [C-1:0]  out_cnt;
   logic          out_valid;
   logic [LW-1:0] level;
   logic          watermark_irq;
   logic [DW-1:0] drop_cnt;
   logic          overflow;

   always #5 clk = ~clk;

   hot_page_queue #(
      .ADDR_SIZE(A), .CNT_SIZE(C), .DEPTH(DEPTH), .WM_LEVEL(WM),
      .DROP_CNT_SIZE(DW), .DEDUP_DEPTH(DD)
   ) dut (
      .clk(clk), .rst_n(rst_n), .epoch(epoch),
      .in_addr(in_addr), .in_cnt(in_cnt), .in_valid(in_valid),
      .out_addr(out_addr), .out_cnt(out_cnt), .out_valid(out_valid), .out_ready(out_ready),
      .level(level), .watermark_irq(watermark_irq),
      .drop_cnt(drop_cnt), .overflow(overflow), .drop_clr(drop_clr)
   );

   // Reference model: exp_q holds accepted reports in order; recent_q the last DD accepted addresses.
   logic [A+C-1:0] exp_q[$];
   logic [A-1:0]   recent_q[$];
   int  m_drop = 0;
   bit  m_ovf = 1'b0, m_wm = 1'b0;
   int  s_level = 0, s_drop = 0;
   bit  s_ovf = 1'b0, s_wm = 1'b0;
   bit  chk_en = 1'b0;
   int  errors = 0, checks = 0;
   int  seq = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: compares DUT state against the snapshot the driver took for this cycle.
   initial begin
      logic [A+C-1:0] e;
      forever begin
         @(negedge clk);
         #2;
         if (chk_en) begin
            check("level", 64'(level), 64'(s_level));
            check("out_valid", 64'(out_valid), 64'(s_level != 0));
            check("drop_cnt", 64'(drop_cnt), 64'(s_drop));
            check("overflow", 64'(overflow), 64'(s_ovf));
            check("watermark_irq", 64'(watermark_irq), 64'(s_wm));
            if (s_level == 0) begin
               check("out_addr_idle", 64'(out_addr), 64'(0));
               check("out_cnt_idle", 64'(out_cnt), 64'(0));
            end else if (out_ready && !epoch) begin
               e = exp_q.pop_front();
               check("out_addr", 64'(out_addr), 64'(e[A+C-1:C]));
               check("out_cnt", 64'(out_cnt), 64'(e[C-1:0]));
            end
         end
      end
   end

   task automatic drive(input logic iv, input logic [A-1:0] a, input logic [C-1:0] c,
                        input logic rdy, input logic ep, input logic clr);
      bit dup, acc, pushed, dropped, popped;
      int nlvl;
      @(negedge clk);
      in_valid = iv; in_addr = a; in_cnt = c; out_ready = rdy; epoch = ep; drop_clr = clr;
      s_level = exp_q.size(); s_drop = m_drop; s_ovf = m_ovf; s_wm = m_wm;
      dup = 1'b0;
`ifdef HOTQ_DEDUP_EN
      foreach (recent_q[i]) if (recent_q[i] == a) dup = 1'b1;
`endif
      acc     = iv && !ep && !dup;
      pushed  = acc && (s_level < DEPTH);
      dropped = acc && (s_level == DEPTH);
      popped  = rdy && !ep && (s_level > 0);
      if (ep) begin
         exp_q.delete();
         recent_q.delete();
      end else if (pushed) begin
         exp_q.push_back({a, c});
         recent_q.push_back(a);
         if (recent_q.size() > DD) void'(recent_q.pop_front());
      end
      nlvl = ep ? 0 : s_level + int'(pushed) - int'(popped);
      m_wm = (nlvl >= WM);
      if (clr) begin
         m_drop = dropped ? 1 : 0;
         m_ovf  = dropped;
      end else if (dropped) begin
         m_ovf = 1'b1;
         if (m_drop < (1 << DW) - 1) m_drop++;
      end
   endtask

   task automatic push(input logic [A-1:0] a, input logic [C-1:0] c, input logic rdy);
      drive(1'b1, a, c, rdy, 1'b0, 1'b0);
   endtask

   task automatic push_new(input logic rdy);
      seq++;
      push(A'(32'h10000 + seq), C'(seq * 7), rdy);
   endtask

   task automatic idle(input logic rdy);
      drive(1'b0, '0, '0, rdy, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      chk_en = 1'b0; rst_n = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; epoch = 1'b0; drop_clr = 1'b0;
      repeat (3) @(negedge clk);
      exp_q.delete(); recent_q.delete();
      m_drop = 0; m_ovf = 1'b0; m_wm = 1'b0;
      s_level = 0; s_drop = 0; s_ovf = 1'b0; s_wm = 1'b0;
      rst_n = 1'b1; chk_en = 1'b1;
   endtask

   initial begin
      logic iv, rdy, ep, clr;
      do_reset();

      // Single entry in and out
      push(21'h00123, 12'd20, 1'b0);
      idle(1'b0);
      idle(1'b1);
      idle(1'b0);

      // Fill, overflow by three, drain with pointer wrap
      for (int i = 0; i < DEPTH; i++) push_new(1'b0);
      for (int i = 0; i < 3; i++) push_new(1'b0);
      for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);

      // Steady push+pop at 63, then push+pop while full
      for (int i = 0; i < DEPTH - 1; i++) push_new(1'b0);
      for (int i = 0; i < 100; i++) push_new(1'b1);
      push_new(1'b0);
      push_new(1'b1);
      for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);

      // Watermark edge
      for (int i = 0; i < WM - 1; i++) push_new(1'b0);
      idle(1'b0);
      push_new(1'b0);
      idle(1'b0);
      idle(1'b1);
      idle(1'b0);
      for (int i = 0; i < WM; i++) idle(1'b1);

      // Epoch with in_valid, then drop_clr coincident with a drop
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < DEPTH; i++) push_new(1'b0);
      for (int i = 0; i < 5; i++) push_new(1'b0);
      for (int i = 0; i < DEPTH - 10; i++) idle(1'b1);
      idle(1'b0);
      drive(1'b1, 21'h0_1234, 12'd9, 1'b0, 1'b1, 1'b0);
      idle(1'b0);
      for (int i = 0; i < DEPTH; i++) push_new(1'b0);
      drive(1'b1, 21'h0_4321, 12'd3, 1'b0, 1'b0, 1'b1);
      idle(1'b0);
      for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);

      // Duplicate-address sequence
      drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      push(21'h00ABC, 12'd1, 1'b0);
      push(21'h00ABC, 12'd2, 1'b0);
      for (int i = 0; i < 8; i++) push_new(1'b0);
      push(21'h00ABC, 12'd3, 1'b0);
      idle(1'b0);
      for (int i = 0; i < 12; i++) idle(1'b1);

      // Randomized traffic at three drain rates, with a mid-run reset
      for (int ph = 0; ph < 3; ph++) begin
         for (int n = 0; n < 800; n++) begin
            iv  = ($urandom_range(0, 99) < 70);
            rdy = ($urandom_range(0, 99) < (ph == 0 ? 30 : (ph == 1 ? 60 : 90)));
            ep  = ($urandom_range(0, 299) == 0);
            clr = ($urandom_range(0, 399) == 0);
            drive(iv, A'($urandom_range(0, 255)), C'($urandom), rdy, ep, clr);
         end
         if (ph == 1) do_reset();
      end
      for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);

      @(negedge clk);
      #3;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
